// File: rtl/rv_register_file_pkg.sv
// Shared constants and types for the RV32I integer register file.
// Used by the register file, its read ports and its bus interface.
package rv_pkg;
   localparam int XLEN   = 32;
   localparam int NREG   = 32;
   localparam int REG_AW = 5;

   typedef logic [REG_AW-1:0] reg_idx_t;
   typedef logic [XLEN-1:0]   xlen_t;

   localparam reg_idx_t REG_ZERO = '0;
endpackage

// File: rtl/rv_register_file_if.sv
// Read/write bus between decode/writeback (master) and the register file (slave).
// Port names match the register file's external pin names.
interface rv_register_file_if;
   import rv_pkg::*;

   reg_idx_t i_Rnum1;
   reg_idx_t i_Rnum2;
   xlen_t    o_Rd1;
   xlen_t    o_Rd2;
   logic     i_Wen;
   reg_idx_t i_Wnum;
   xlen_t    i_Wd;

   modport master (
      output i_Rnum1, i_Rnum2, i_Wen, i_Wnum, i_Wd,
      input  o_Rd1, o_Rd2
   );

   modport slave (
      input  i_Rnum1, i_Rnum2, i_Wen, i_Wnum, i_Wd,
      output o_Rd1, o_Rd2
   );
endinterface

// File: rtl/rv_register_file_rd_port.sv
// Combinational read mux over the flattened register array.
// Index 0 is forced to zero regardless of what the array holds.
module rv_register_file_rd_port #(
   parameter int XLEN = rv_pkg::XLEN,
   parameter int NREG = rv_pkg::NREG,
   parameter int AW   = rv_pkg::REG_AW
) (
   input  logic [NREG-1:0][XLEN-1:0] regs,
   input  logic [AW-1:0]             idx,
   output logic [XLEN-1:0]           data
);

   // index-to-data mux with x0 zero gating
   always_comb begin
      data = '0;
      if (idx == AW'(0)) begin
         data = '0;
      end else begin
         data = regs[idx];
      end
   end

endmodule

// File: rtl/rv_register_file.sv
// RV32I general-purpose register file: x1..x31 are flops, x0 reads zero.
// Two asynchronous read ports, one synchronous write port, no write-through bypass.
module rv_register_file #(
   parameter int XLEN = rv_pkg::XLEN,
   parameter int NREG = rv_pkg::NREG,
   parameter int AW   = rv_pkg::REG_AW
) (
   input logic               i_clk,
   input logic               i_rst_n,
   rv_register_file_if.slave rf
);

   logic [NREG-1:1][XLEN-1:0] regs_r;
   logic [NREG-1:0][XLEN-1:0] regs_s;
   logic [NREG-1:1]           wen_s;

   // per-register write-enable decode; x0 never gets an enable
   always_comb begin
      wen_s = '0;
      for (int i = 1; i < NREG; i++) begin
         if (rf.i_Wen && (rf.i_Wnum == AW'(i))) begin
            wen_s[i] = 1'b1;
         end else begin
            wen_s[i] = 1'b0;
         end
      end
   end

   // register storage; async reset clears everything and blocks writes
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         regs_r <= '0;
      end else begin
         for (int i = 1; i < NREG; i++) begin
            if (wen_s[i]) begin
               regs_r[i] <= rf.i_Wd;
            end else begin
               regs_r[i] <= regs_r[i];
            end
         end
      end
   end

   // x0 has no storage: slot 0 of the read view is a constant zero
   assign regs_s = {regs_r, {XLEN{1'b0}}};

   rv_register_file_rd_port #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) u_rd1 (
      .regs (regs_s),
      .idx  (rf.i_Rnum1),
      .data (rf.o_Rd1)
   );

   rv_register_file_rd_port #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) u_rd2 (
      .regs (regs_s),
      .idx  (rf.i_Rnum2),
      .data (rf.o_Rd2)
   );

endmodule

// File: tb/tb_rv_register_file.sv
// Self-checking bench for rv_register_file: table-driven write/read vectors
// plus directed sequences for reset, full sweep, disable and read-during-write.
module tb_rv_register_file;

   typedef struct {
      logic        wen;
      logic [4:0]  wnum;
      logic [31:0] wd;
      logic [4:0]  r1;
      logic [4:0]  r2;
      logic [31:0] e1;
      logic [31:0] e2;
   } vec_t;

   logic clk;
   logic rst_n;
   int   n_total;
   int   n_pass;
   logic [31:0] mdl [32];

   rv_register_file_if rf ();

   rv_register_file dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .rf      (rf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end else begin
         n_pass++;
      end
   endtask

   // advance to 1 time unit after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic wen, input logic [4:0] wnum, input logic [31:0] wd);
      rf.i_Wen  = wen;
      rf.i_Wnum = wnum;
      rf.i_Wd   = wd;
   endtask

   vec_t tbl [7];

   initial begin
      logic [31:0] last;
      logic [31:0] rnd;
      n_total = 0;
      n_pass  = 0;
      for (int i = 0; i < 32; i++) mdl[i] = 32'h0;

      rst_n      = 1'b0;
      rf.i_Rnum1 = 5'd5;
      rf.i_Rnum2 = 5'd31;
      drive(1'b0, 5'd0, 32'h0);

      // vectors: write on the edge, then read after it
      tbl[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd0,  32'hDEADBEEF, 32'h0};
      tbl[1] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd5,  32'h0,        32'hDEADBEEF};
      tbl[2] = '{1'b0, 5'd5,  32'h00000001, 5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF};
      tbl[3] = '{1'b1, 5'd31, 32'hA5A5A5A5, 5'd31, 5'd31, 32'hA5A5A5A5, 32'hA5A5A5A5};
      tbl[4] = '{1'b1, 5'd31, 32'h12345678, 5'd31, 5'd5,  32'h12345678, 32'hDEADBEEF};
      tbl[5] = '{1'b1, 5'd1,  32'h00000001, 5'd1,  5'd31, 32'h00000001, 32'h12345678};
      tbl[6] = '{1'b1, 5'd16, 32'h80000000, 5'd16, 5'd0,  32'h80000000, 32'h0};

      #3;
      check("reset_rd1", rf.o_Rd1, 32'h0);
      check("reset_rd2", rf.o_Rd2, 32'h0);
      tick();
      rst_n = 1'b1;

      for (int v = 0; v < 7; v++) begin
         drive(tbl[v].wen, tbl[v].wnum, tbl[v].wd);
         tick();
         drive(1'b0, 5'd0, 32'h0);
         rf.i_Rnum1 = tbl[v].r1;
         rf.i_Rnum2 = tbl[v].r2;
         #1;
         check($sformatf("vec%0d_rd1", v), rf.o_Rd1, tbl[v].e1);
         check($sformatf("vec%0d_rd2", v), rf.o_Rd2, tbl[v].e2);
      end

      // async reset mid-cycle, writes blocked while held
      rf.i_Rnum1 = 5'd5;
      rf.i_Rnum2 = 5'd31;
      #1;
      rst_n = 1'b0;
      #1;
      check("async_rst_rd1", rf.o_Rd1, 32'h0);
      check("async_rst_rd2", rf.o_Rd2, 32'h0);
      drive(1'b1, 5'd5, 32'hCAFEF00D);
      tick();
      check("rst_blocks_wr", rf.o_Rd1, 32'h0);
      drive(1'b0, 5'd0, 32'h0);
      rst_n = 1'b1;
      tick();
      check("post_rst_x5", rf.o_Rd1, 32'h0);
      check("post_rst_x31", rf.o_Rd2, 32'h0);

      // write-all then sweep all index pairs
      for (int i = 1; i < 32; i++) begin
         drive(1'b1, 5'(i), 32'(i));
         tick();
         mdl[i] = 32'(i);
      end
      drive(1'b0, 5'd0, 32'h0);
      for (int i = 0; i < 32; i++) begin
         for (int j = 0; j < 32; j++) begin
            rf.i_Rnum1 = 5'(i);
            rf.i_Rnum2 = 5'(j);
            #1;
            check($sformatf("sweep_rd1_%0d_%0d", i, j), rf.o_Rd1, 32'(i));
            check($sformatf("sweep_rd2_%0d_%0d", i, j), rf.o_Rd2, 32'(j));
         end
      end

      // x0 write attempt after full population
      drive(1'b1, 5'd0, 32'hFFFFFFFF);
      rf.i_Rnum1 = 5'd0;
      tick();
      check("x0_write", rf.o_Rd1, 32'h0);

      // write disable over several edges
      drive(1'b0, 5'd7, 32'h12345678);
      rf.i_Rnum1 = 5'd7;
      repeat (3) tick();
      check("wen_off_x7", rf.o_Rd1, 32'd7);

      // read during write: old value until the committing edge
      for (int i = 1; i < 32; i++) begin
         rf.i_Rnum1 = 5'(i);
         #1;
         last = rf.o_Rd1;
         check($sformatf("rdw_pre_%0d", i), last, mdl[i]);
         rnd = $urandom;
         drive(1'b1, 5'(i), rnd);
         #1;
         check($sformatf("rdw_nobypass_%0d", i), rf.o_Rd1, mdl[i]);
         tick();
         drive(1'b0, 5'd0, 32'h0);
         mdl[i] = rnd;
         check($sformatf("rdw_commit_%0d", i), rf.o_Rd1, mdl[i]);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
